// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - word-addressed RAM responder with programmable access latency
//
// Models the memory side of the CPU/RAM request interface. An initiator holds
// ramREN or ramWEN (with ramaddr/ramstore) until it sees ramstate==ACCESS.
// Each completed read or write is counted.
//
// Parameters:
//   LAT     wait cycles spent in BUSY before ACCESS (0..15)
//   ADDR_W  word-index bits; array depth is 2**ADDR_W words
//
// Ports:
//   CLK       in   clock, rising edge
//   nRST      in   asynchronous active-low reset
//   ramREN    in   read request (held level)
//   ramWEN    in   write request (held level)
//   ramaddr   in   byte address; word index = ramaddr[ADDR_W+1:2]
//   ramstore  in   write data, sampled on the edge entering ACCESS
//   ramload   out  registered read data, holds its last read value
//   ramstate  out  FREE=0, BUSY=1, ACCESS=2, ERROR=3 (registered)
//   rdcount   out  completed reads, wraps at 2**32
//   wrcount   out  completed writes, wraps at 2**32

module ram_responder #(
  parameter int LAT    = 2,
  parameter int ADDR_W = 10
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate,
  output logic [31:0] rdcount,
  output logic [31:0] wrcount
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } state_t;

  // Counter reload for the BUSY phase; unused when LAT is 0.
  localparam logic [3:0] LAT_LOAD = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

  state_t            state, next_state;
  logic [3:0]        cnt, next_cnt;
  logic              lat_ren, lat_wen;
  logic [31:0]       lat_addr;
  logic              latch_req;
  logic              do_access;
  logic              do_read, do_write;

  logic              req_any;
  logic              req_valid;
  logic              req_illegal;
  logic              req_changed;
  logic [ADDR_W-1:0] idx;

  logic [31:0]       mem [0:(2**ADDR_W)-1];

  assign req_any     = ramREN | ramWEN;
  assign req_valid   = (ramREN ^ ramWEN) && (ramaddr[1:0] == 2'b00);
  assign req_illegal = (ramREN & ramWEN) || (req_any && (ramaddr[1:0] != 2'b00));
  // Any deviation from the request latched in FREE aborts the pending access.
  assign req_changed = !req_any || (ramREN != lat_ren) || (ramWEN != lat_wen) ||
                       (ramaddr != lat_addr);
  assign idx         = ramaddr[ADDR_W+1:2];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= FREE;
      cnt      <= 4'd0;
      lat_ren  <= 1'b0;
      lat_wen  <= 1'b0;
      lat_addr <= 32'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (latch_req) begin
        lat_ren  <= ramREN;
        lat_wen  <= ramWEN;
        lat_addr <= ramaddr;
      end
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    latch_req  = 1'b0;
    do_access  = 1'b0;
    case (state)
      FREE: begin
        if (req_illegal) begin
          next_state = ERROR;
        end else if (req_valid) begin
          latch_req = 1'b1;
          if (LAT == 0) begin
            next_state = ACCESS;
            do_access  = 1'b1;
          end else begin
            next_state = BUSY;
            next_cnt   = LAT_LOAD;
          end
        end
      end
      BUSY: begin
        if (req_changed) begin
          next_state = FREE;
        end else if (req_illegal) begin
          next_state = ERROR;
        end else if (cnt == 4'd0) begin
          next_state = ACCESS;
          do_access  = 1'b1;
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end
      ACCESS: begin
        next_state = FREE;
      end
      ERROR: begin
        if (!req_illegal) begin
          next_state = FREE;
        end
      end
      default: begin
        next_state = FREE;
      end
    endcase
  end

  // The access uses the live inputs: in BUSY they are known to match the
  // latched request, so ramstore is the value present on the ACCESS edge.
  assign do_read  = do_access & ramREN;
  assign do_write = do_access & ramWEN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ramload <= 32'd0;
      rdcount <= 32'd0;
      wrcount <= 32'd0;
    end else begin
      if (do_read) begin
        ramload <= mem[idx];
        rdcount <= rdcount + 32'd1;
      end
      if (do_write) begin
        wrcount <= wrcount + 32'd1;
      end
    end
  end

  // Array contents survive reset.
  always_ff @(posedge CLK) begin
    if (do_write) begin
      mem[idx] <= ramstore;
    end
  end

  assign ramstate = state;

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - scoreboard bench for ram_responder at LAT 2, 0 and 4

module tb_ram_responder;

  logic        CLK;
  logic        nRST;
  logic [2:0]  ren;
  logic [2:0]  wen;
  logic [31:0] addr  [3];
  logic [31:0] store [3];
  logic [31:0] ld    [3];
  logic [1:0]  st    [3];
  logic [31:0] rc    [3];
  logic [31:0] wc    [3];

  int n_checks;
  int n_err;

  typedef struct {
    int          inst;
    bit          wr;
    logic [31:0] ld;
    logic [31:0] rc;
    logic [31:0] wc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  ram_responder #(.LAT(2), .ADDR_W(10)) u_lat2 (
    .CLK(CLK), .nRST(nRST), .ramREN(ren[0]), .ramWEN(wen[0]),
    .ramaddr(addr[0]), .ramstore(store[0]), .ramload(ld[0]),
    .ramstate(st[0]), .rdcount(rc[0]), .wrcount(wc[0])
  );

  ram_responder #(.LAT(0), .ADDR_W(10)) u_lat0 (
    .CLK(CLK), .nRST(nRST), .ramREN(ren[1]), .ramWEN(wen[1]),
    .ramaddr(addr[1]), .ramstore(store[1]), .ramload(ld[1]),
    .ramstate(st[1]), .rdcount(rc[1]), .wrcount(wc[1])
  );

  ram_responder #(.LAT(4), .ADDR_W(10)) u_lat4 (
    .CLK(CLK), .nRST(nRST), .ramREN(ren[2]), .ramWEN(wen[2]),
    .ramaddr(addr[2]), .ramstore(store[2]), .ramload(ld[2]),
    .ramstate(st[2]), .rdcount(rc[2]), .wrcount(wc[2])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every ACCESS cycle consumes one scoreboard entry.
  always @(negedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      if (nRST === 1'b1 && st[i] == 2'd2) begin
        if (q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_access: inst %0d in ACCESS, expected no access", i);
        end else begin
          mon_e = q.pop_front();
          chk("sb_inst", 32'(i), 32'(mon_e.inst));
          if (!mon_e.wr) chk("sb_ramload", ld[i], mon_e.ld);
          chk("sb_rdcount", rc[i], mon_e.rc);
          chk("sb_wrcount", wc[i], mon_e.wc);
        end
      end
    end
  end

  // Called at #1 after an edge that left instance i in FREE with no request.
  task automatic do_req(input int i, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input int lat, input logic [31:0] exp_ld,
                        input logic [31:0] exp_rc, input logic [31:0] exp_wc);
    exp_t e;
    int   n;
    bit   got;
    e.inst = i; e.wr = wr; e.ld = exp_ld; e.rc = exp_rc; e.wc = exp_wc;
    q.push_back(e);
    ren[i]   = !wr;
    wen[i]   = wr;
    addr[i]  = a;
    store[i] = d;
    n   = 0;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge CLK);
      #1;
      n++;
      if (st[i] == 2'd2) got = 1;
    end
    chk("req_latency", 32'(n), 32'(lat + 1));
    ren[i] = 1'b0;
    wen[i] = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    exp_t e;
    int   n;
    bit   got;
    n_checks = 0;
    n_err    = 0;
    nRST     = 1'b0;
    ren      = 3'b000;
    wen      = 3'b000;
    for (int i = 0; i < 3; i++) begin
      addr[i]  = 32'd0;
      store[i] = 32'd0;
    end

    // Reset and idle
    repeat (3) tick();
    chk("rst_state", 32'(st[0]), 32'd0);
    chk("rst_ramload", ld[0], 32'd0);
    chk("rst_rdcount", rc[0], 32'd0);
    chk("rst_wrcount", wc[0], 32'd0);
    nRST = 1'b1;
    tick();

    // Reset asserted mid-BUSY
    ren[0]  = 1'b1;
    addr[0] = 32'h10;
    tick();
    chk("busy_before_rst", 32'(st[0]), 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("async_rst_state", 32'(st[0]), 32'd0);
    chk("async_rst_rdcount", rc[0], 32'd0);
    ren[0] = 1'b0;
    tick();
    nRST = 1'b1;
    repeat (3) tick();
    chk("idle_state", 32'(st[0]), 32'd0);
    chk("idle_rdcount", rc[0], 32'd0);

    // Write then read, LAT=2, plus address wrap
    do_req(0, 1'b1, 32'h10,   32'hDEADBEEF, 2, 32'h0,        32'd0, 32'd1);
    do_req(0, 1'b0, 32'h10,   32'h0,        2, 32'hDEADBEEF, 32'd1, 32'd1);
    do_req(0, 1'b1, 32'h1000, 32'h1234,     2, 32'h0,        32'd1, 32'd2);
    do_req(0, 1'b0, 32'h0,    32'h0,        2, 32'h1234,     32'd2, 32'd2);

    // Errors: both strobes, then misaligned write
    ren[0] = 1'b1; wen[0] = 1'b1; addr[0] = 32'h10; store[0] = 32'h5555_5555;
    tick();
    chk("err_both", 32'(st[0]), 32'd3);
    tick();
    chk("err_both_held", 32'(st[0]), 32'd3);
    ren[0] = 1'b0; wen[0] = 1'b0;
    tick();
    chk("err_exit", 32'(st[0]), 32'd0);
    wen[0] = 1'b1; addr[0] = 32'h6; store[0] = 32'h7777_7777;
    tick();
    chk("err_misaligned", 32'(st[0]), 32'd3);
    wen[0] = 1'b0;
    tick();
    chk("err_exit2", 32'(st[0]), 32'd0);
    chk("err_ramload_hold", ld[0], 32'h1234);
    chk("err_rdcount", rc[0], 32'd2);
    chk("err_wrcount", wc[0], 32'd2);
    do_req(0, 1'b0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 32'd3, 32'd2);

    // LAT=0 back-to-back reads
    do_req(1, 1'b1, 32'h4, 32'hA5A5_0001, 0, 32'h0, 32'd0, 32'd1);
    ren[1]  = 1'b1;
    addr[1] = 32'h4;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        e.inst = 1; e.wr = 1'b0; e.ld = 32'hA5A5_0001;
        e.rc = 32'(k / 2 + 1); e.wc = 32'd1;
        q.push_back(e);
      end
      tick();
      chk("lat0_seq", 32'(st[1]), (k % 2 == 0) ? 32'd2 : 32'd0);
    end
    ren[1] = 1'b0;
    tick();
    chk("lat0_rdcount", rc[1], 32'd4);

    // Abort, LAT=4
    do_req(2, 1'b1, 32'hC, 32'hC0C0_0003, 4, 32'h0, 32'd0, 32'd1);
    do_req(2, 1'b1, 32'h8, 32'h0000_8888, 4, 32'h0, 32'd0, 32'd2);
    ren[2]  = 1'b1;
    addr[2] = 32'h8;
    tick();
    chk("abort_busy1", 32'(st[2]), 32'd1);
    tick();
    chk("abort_busy2", 32'(st[2]), 32'd1);
    addr[2] = 32'hC;
    tick();
    chk("abort_free", 32'(st[2]), 32'd0);
    chk("abort_rdcount", rc[2], 32'd0);
    chk("abort_ramload", ld[2], 32'd0);
    e.inst = 2; e.wr = 1'b0; e.ld = 32'hC0C0_0003; e.rc = 32'd1; e.wc = 32'd2;
    q.push_back(e);
    n   = 0;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      n++;
      if (st[2] == 2'd2) got = 1;
    end
    chk("abort_relatency", 32'(n), 32'd5);
    ren[2] = 1'b0;
    tick();
    do_req(2, 1'b0, 32'h8, 32'h0, 4, 32'h0000_8888, 32'd2, 32'd2);

    repeat (3) tick();
    chk("sb_drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
